// File: rtl/game_pkg.sv
// game_pkg: shared game constants and types.
// Contents:
//   SCREEN_W, SCREEN_H  visible area in pixels and lines
//   OFFSCREEN           coordinate value of a parked sprite
//   rgb222_t            RGB222 pixel colour
//   bullet_state_t      player bullet states
package game_pkg;
    localparam logic [9:0] SCREEN_W  = 10'd640;
    localparam logic [9:0] SCREEN_H  = 10'd480;
    localparam logic [9:0] OFFSCREEN = 10'h3FF;
    typedef logic [5:0] rgb222_t;
    typedef enum logic [1:0] {IDLE, FLYING, HIT} bullet_state_t;
endpackage

// File: rtl/bullet_controller_if.sv
// bullet_controller_if: signals between the bullet stage and its neighbours.
// Signals:
//   fire, shooterPosX/Y     inputs from the player/shooter block
//   collisionFlag           hit report from the enemy block
//   horCnt, verCnt          VGA raster position
//   bulletPosX/Y, bulletActive, hitPulse, shotsFired, rgbContentBullet  bullet outputs
// Modports: master = the bullet controller, slave = its surroundings.
interface bullet_controller_if;
    import game_pkg::*;
    logic       fire;
    logic [9:0] shooterPosX;
    logic [9:0] shooterPosY;
    logic       collisionFlag;
    logic [9:0] horCnt;
    logic [9:0] verCnt;
    logic [9:0] bulletPosX;
    logic [9:0] bulletPosY;
    logic       bulletActive;
    logic       hitPulse;
    logic [7:0] shotsFired;
    rgb222_t    rgbContentBullet;
    modport master (
        input  fire, shooterPosX, shooterPosY, collisionFlag, horCnt, verCnt,
        output bulletPosX, bulletPosY, bulletActive, hitPulse, shotsFired, rgbContentBullet
    );
    modport slave (
        output fire, shooterPosX, shooterPosY, collisionFlag, horCnt, verCnt,
        input  bulletPosX, bulletPosY, bulletActive, hitPulse, shotsFired, rgbContentBullet
    );
endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one registered pulse per frame at the start of line SCREEN_H.
// Ports:
//   clk, reset  clock and synchronous active-low reset
//   horCnt_i    VGA horizontal counter
//   verCnt_i    VGA vertical counter
//   tick_o      one-cycle frame pulse
module frame_tick_gen
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] horCnt_i,
    input  logic [9:0] verCnt_i,
    output logic       tick_o
);
    logic at_line_d;
    logic at_line_q;
    logic tick_q;

    assign at_line_d = (horCnt_i == 10'd0) && (verCnt_i == SCREEN_H);

    // Edge detect so a counter stalled on the trigger point still yields one tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            at_line_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            at_line_q <= at_line_d;
            tick_q    <= at_line_d && !at_line_q;
        end
    end

    assign tick_o = tick_q;
endmodule

// File: rtl/bullet_controller.sv
// bullet_controller: launches, moves, retires and draws the single player bullet.
// Ports:
//   clk    system clock
//   reset  synchronous active-low reset
//   bus    bullet_controller_if.master: fire/shooter/collision/raster in,
//          bullet coordinates, active, hit pulse, shot count and pixel out
module bullet_controller
    import game_pkg::*;
#(
    parameter int      BULLET_W        = 4,
    parameter int      BULLET_H        = 8,
    parameter int      SPEED           = 4,
    parameter int      SHOOTER_W       = 16,
    parameter int      COOLDOWN_FRAMES = 15,
    parameter rgb222_t BULLET_COLOR    = 6'b111100
) (
    input  logic                 clk,
    input  logic                 reset,
    bullet_controller_if.master  bus
);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    bullet_state_t state_q;
    logic          fire_q;
    logic          fedge_q;
    logic          active_q;
    logic          hit_q;
    logic [9:0]    posx_q;
    logic [9:0]    posy_q;
    logic [CW-1:0] cool_q;
    logic [7:0]    shots_q;
    rgb222_t       rgb_q;
    logic          tick;
    logic          accept_d;
    logic          pix_d;

    frame_tick_gen u_tick (
        .clk      (clk),
        .reset    (reset),
        .horCnt_i (bus.horCnt),
        .verCnt_i (bus.verCnt),
        .tick_o   (tick)
    );

    assign accept_d = fedge_q && (cool_q == '0) && (bus.shooterPosY >= 10'(BULLET_H));

    // 11-bit compares so a window ending past 1023 does not wrap.
    assign pix_d = active_q
                && ({1'b0, bus.horCnt} >= {1'b0, posx_q})
                && ({1'b0, bus.horCnt} <  {1'b0, posx_q} + 11'(BULLET_W))
                && ({1'b0, bus.verCnt} >= {1'b0, posy_q})
                && ({1'b0, bus.verCnt} <  {1'b0, posy_q} + 11'(BULLET_H));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            fire_q   <= 1'b1;
            fedge_q  <= 1'b0;
            active_q <= 1'b0;
            hit_q    <= 1'b0;
            posx_q   <= OFFSCREEN;
            posy_q   <= OFFSCREEN;
            cool_q   <= '0;
            shots_q  <= '0;
            rgb_q    <= '0;
        end else begin
            fire_q  <= bus.fire;
            fedge_q <= bus.fire && !fire_q;
            hit_q   <= 1'b0;
            rgb_q   <= pix_d ? BULLET_COLOR : '0;
            if (tick && cool_q != '0)
                cool_q <= cool_q - CW'(1);
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        state_q  <= FLYING;
                        active_q <= 1'b1;
                        posx_q   <= bus.shooterPosX + 10'(SHOOTER_W / 2 - BULLET_W / 2);
                        posy_q   <= bus.shooterPosY - 10'(BULLET_H);
                        shots_q  <= shots_q + 8'd1;
                    end
                end
                FLYING: begin
                    if (bus.collisionFlag) begin
                        state_q  <= HIT;
                        active_q <= 1'b0;
                    end else if (tick && posy_q < 10'(SPEED)) begin
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                        posx_q   <= OFFSCREEN;
                        posy_q   <= OFFSCREEN;
                        cool_q   <= CW'(COOLDOWN_FRAMES);
                    end else if (tick) begin
                        posy_q <= posy_q - 10'(SPEED);
                    end
                end
                HIT: begin
                    state_q <= IDLE;
                    hit_q   <= 1'b1;
                    posx_q  <= OFFSCREEN;
                    posy_q  <= OFFSCREEN;
                    cool_q  <= CW'(COOLDOWN_FRAMES);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.bulletPosX       = posx_q;
    assign bus.bulletPosY       = posy_q;
    assign bus.bulletActive     = active_q;
    assign bus.hitPulse         = hit_q;
    assign bus.shotsFired       = shots_q;
    assign bus.rgbContentBullet = rgb_q;
endmodule
